// File: rtl/day_3_pkg.sv
// -----------------------------------------------------------------------------
// day_3_pkg
// Shared types and constants for the day-3 joltage scan controller.
//   state_t  : controller FSM states (IDLE, SCAN, COMMIT, DONE)
//   DIGIT_W  : width of one incoming decimal digit
//   PAIR_W   : width of a two-digit value (0..99)
//   pair_t   : two-digit value type
//   digit_t  : single digit type
// -----------------------------------------------------------------------------
package day_3_pkg;

    localparam int DIGIT_W = 4;
    localparam int PAIR_W  = 7;

    typedef logic [PAIR_W-1:0]  pair_t;
    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/day_3_pair_unit.sv
// -----------------------------------------------------------------------------
// day_3_pair_unit
// Running best-pair datapath for one bank. Tracks the largest digit seen so far
// (tens) and the largest ordered two-digit value tens*10+d over the bank.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   clear : synchronous clear of all per-bank state
//   en    : accept digit d this cycle
//   d     : digit, already sanitised to 0..9
//   best  : best two-digit value of the bank so far
//   n     : digits seen in this bank, saturating at 2
// -----------------------------------------------------------------------------
module day_3_pair_unit
    import day_3_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   en,
    input  digit_t d,
    output pair_t  best,
    output logic [1:0] n
);

    digit_t tens;
    pair_t  cand;

    // Candidate formed with the tens digit as it was before this digit arrives;
    // 9*10+9 = 99 fits in PAIR_W bits.
    assign cand = pair_t'(tens) * pair_t'(10) + pair_t'(d);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values (cand and tens below both see the old tens).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            best <= '0;
            n    <= '0;
        end else if (clear) begin
            tens <= '0;
            best <= '0;
            n    <= '0;
        end else if (en) begin
            if (n == 2'd0) begin
                tens <= d;
            end else begin
                best <= (cand > best) ? cand : best;
                tens <= (d > tens) ? d : tens;
            end
            if (n != 2'd2) begin
                n <= n + 2'd1;
            end
        end
    end

endmodule

// File: rtl/day_3_sched.sv
// -----------------------------------------------------------------------------
// day_3_sched
// Sequential controller for the day-3 joltage computation. Streams one digit
// per cycle through day_3_pair_unit, commits each bank's best pair into a
// running total and raises finished after BANKS banks.
// Parameters:
//   BANKS : banks per run
//   SUM_W : accumulator width
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start                     : begins a run (only from IDLE or DONE)
//   digit_valid / digit_ready : digit handshake (ready is high exactly in SCAN)
//   digit, digit_last         : digit payload, last-of-bank marker
//   busy                      : high in SCAN and COMMIT
//   finished                  : high in DONE
//   output_sum                : accumulated total (wraps modulo 2^SUM_W)
//   bank_count                : banks committed this run
//   short_bank_err            : sticky, a bank had fewer than two digits
//   digit_err                 : sticky, a digit above 9 was accepted
// Optional (macro DAY3_BANK_RESULT_EN):
//   bank_result_valid         : one-cycle pulse the cycle after each COMMIT
//   bank_result               : committed bank value, held until next pulse
// -----------------------------------------------------------------------------
module day_3_sched
    import day_3_pkg::*;
#(
    parameter int BANKS = 200,
    parameter int SUM_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               digit_last,
    output logic               busy,
    output logic               finished,
    output logic [SUM_W-1:0]   output_sum,
    output logic [15:0]        bank_count,
    output logic               short_bank_err,
    output logic               digit_err
`ifdef DAY3_BANK_RESULT_EN
    ,
    output logic               bank_result_valid,
    output logic [PAIR_W-1:0]  bank_result
`endif
);

    localparam logic [15:0] LAST_BANK = 16'(BANKS - 1);

    state_t     state;
    state_t     state_next;
    logic       launch;
    logic       accept;
    logic       commit;
    logic       bad_digit;
    digit_t     d_clean;
    pair_t      pair_best;
    logic [1:0] pair_n;
    pair_t      commit_val;

    // Handshake and status outputs decode the state register only.
    assign digit_ready = (state == SCAN);
    assign busy        = (state == SCAN) || (state == COMMIT);
    assign finished    = (state == DONE);

    assign launch    = start && ((state == IDLE) || (state == DONE));
    assign accept    = digit_valid && digit_ready;
    assign commit    = (state == COMMIT);
    assign bad_digit = (digit > digit_t'(9));
    assign d_clean   = bad_digit ? '0 : digit;

    // Short banks contribute nothing.
    assign commit_val = (pair_n == 2'd2) ? pair_best : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (accept && digit_last) state_next = COMMIT;
            COMMIT:  state_next = (bank_count == LAST_BANK) ? DONE : SCAN;
            DONE:    if (start) state_next = SCAN;
            default: state_next = IDLE;
        endcase
    end

    // Per-bank state is wiped at run start and on every COMMIT, so the next
    // SCAN always begins from an empty bank.
    day_3_pair_unit u_pair (
        .clk   (clk),
        .rst   (rst),
        .clear (launch || commit),
        .en    (accept),
        .d     (d_clean),
        .best  (pair_best),
        .n     (pair_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_sum     <= '0;
            bank_count     <= '0;
            short_bank_err <= 1'b0;
            digit_err      <= 1'b0;
        end else if (launch) begin
            output_sum     <= '0;
            bank_count     <= '0;
            short_bank_err <= 1'b0;
            digit_err      <= 1'b0;
        end else begin
            if (accept && bad_digit) begin
                digit_err <= 1'b1;
            end
            if (commit) begin
                output_sum <= output_sum + SUM_W'(commit_val);
                bank_count <= bank_count + 16'd1;
                if (pair_n != 2'd2) begin
                    short_bank_err <= 1'b1;
                end
            end
        end
    end

`ifdef DAY3_BANK_RESULT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_result_valid <= 1'b0;
            bank_result       <= '0;
        end else begin
            bank_result_valid <= commit;
            if (commit) begin
                bank_result <= commit_val;
            end
        end
    end
`endif

endmodule

// File: tb/tb_day_3_sched.sv
// -----------------------------------------------------------------------------
// tb_day_3_sched
// Self-checking bench for day_3_sched with BANKS=2. Each table entry is one run
// of two banks plus the expected run totals; per-bank expectations come from a
// brute-force model and are queued when a bank is driven, then popped when the
// DUT's bank_count advances.
// -----------------------------------------------------------------------------
module tb_day_3_sched;

    localparam int BANKS = 2;
    localparam int SUM_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             digit_valid;
    logic             digit_ready;
    logic [3:0]       digit;
    logic             digit_last;
    logic             busy;
    logic             finished;
    logic [SUM_W-1:0] output_sum;
    logic [15:0]      bank_count;
    logic             short_bank_err;
    logic             digit_err;
`ifdef DAY3_BANK_RESULT_EN
    logic             bank_result_valid;
    logic [6:0]       bank_result;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];

    typedef struct {
        string a;
        string b;
        bit    gaps;
        int    exp_sum;
        bit    exp_short;
        bit    exp_derr;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    day_3_sched #(
        .BANKS (BANKS),
        .SUM_W (SUM_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .digit_valid    (digit_valid),
        .digit_ready    (digit_ready),
        .digit          (digit),
        .digit_last     (digit_last),
        .busy           (busy),
        .finished       (finished),
        .output_sum     (output_sum),
        .bank_count     (bank_count),
        .short_bank_err (short_bank_err),
        .digit_err      (digit_err)
`ifdef DAY3_BANK_RESULT_EN
        ,
        .bank_result_valid (bank_result_valid),
        .bank_result       (bank_result)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int dig_of(byte c);
        int v;
        v = int'(c) - 48;
        return (v > 9 || v < 0) ? 0 : v;
    endfunction

    // Exhaustive ordered-pair search, independent of the streaming algorithm.
    function automatic int model_best(string s);
        int best;
        int v;
        best = 0;
        for (int i = 0; i < s.len(); i++) begin
            for (int j = i + 1; j < s.len(); j++) begin
                v = dig_of(s[i]) * 10 + dig_of(s[j]);
                if (v > best) best = v;
            end
        end
        return best;
    endfunction

    // Scoreboard side: every bank_count step must add exactly the queued value.
    logic [15:0]      prev_count = '0;
    logic [SUM_W-1:0] prev_sum   = '0;
    always @(negedge clk) begin
        logic [SUM_W-1:0] delta;
        int exp_v;
        if (rst === 1'b0 && bank_count == prev_count + 16'd1) begin
            if (exp_q.size() == 0) begin
                check("bank_commit_unexpected", 32'(bank_count), 32'(prev_count));
            end else begin
                exp_v = exp_q.pop_front();
                delta = output_sum - prev_sum;
                check("bank_add", 32'(delta), exp_v);
`ifdef DAY3_BANK_RESULT_EN
                check("bank_result_valid", 32'(bank_result_valid), 1);
                check("bank_result", 32'(bank_result), exp_v);
`endif
            end
        end
`ifdef DAY3_BANK_RESULT_EN
        else if (rst === 1'b0 && bank_result_valid === 1'b1) begin
            check("bank_result_spurious", 32'(bank_result_valid), 0);
        end
`endif
        prev_count = bank_count;
        prev_sum   = output_sum;
    end

    task automatic send_digit(input logic [3:0] d, input bit last, input bit gaps);
        bit took;
        int budget;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                digit_valid = 1'b0;
                digit       = 4'($urandom_range(0, 15));
                digit_last  = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        digit_valid = 1'b1;
        digit       = d;
        digit_last  = last;
        took   = 1'b0;
        budget = 0;
        while (!took && budget < 50) begin
            @(negedge clk);
            took = digit_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!took) check("accept_timeout", 32'(took), 1);
        digit_valid = 1'b0;
        digit_last  = 1'b0;
    endtask

    task automatic send_bank(input string s, input int limit, input bit gaps);
        if (limit >= s.len()) exp_q.push_back(model_best(s));
        for (int i = 0; i < s.len() && i < limit; i++) begin
            send_digit(4'(int'(s[i]) - 48), (i == s.len() - 1), gaps);
        end
    endtask

    task automatic run(input int idx);
        int  t0;
        int  budget;
        bit  done;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        check("start_sum_clear", 32'(output_sum), 0);
        check("start_count_clear", 32'(bank_count), 0);
        check("start_finished_drop", 32'(finished), 0);
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(digit_ready), 1);
        check("start_short_clear", 32'(short_bank_err), 0);
        check("start_derr_clear", 32'(digit_err), 0);
        send_bank(tbl[idx].a, 99, tbl[idx].gaps);
        send_bank(tbl[idx].b, 99, tbl[idx].gaps);
        done   = 1'b0;
        budget = 0;
        while (!done && budget < 200) begin
            @(negedge clk);
            done = finished;
            budget++;
        end
        check("finished_seen", 32'(done), 1);
        if (!tbl[idx].gaps)
            check("run_latency", cyc - t0, tbl[idx].a.len() + tbl[idx].b.len() + BANKS);
        check("run_sum", 32'(output_sum), tbl[idx].exp_sum);
        check("run_count", 32'(bank_count), BANKS);
        check("run_short_err", 32'(short_bank_err), 32'(tbl[idx].exp_short));
        check("run_digit_err", 32'(digit_err), 32'(tbl[idx].exp_derr));
        check("done_busy", 32'(busy), 0);
        check("done_ready", 32'(digit_ready), 0);
        @(posedge clk);
        #1;
        check("finished_hold", 32'(finished), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(digit_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_finished"}, 32'(finished), 0);
        check({tag, "_sum"}, 32'(output_sum), 0);
        check({tag, "_count"}, 32'(bank_count), 0);
        check({tag, "_short"}, 32'(short_bank_err), 0);
        check({tag, "_derr"}, 32'(digit_err), 0);
`ifdef DAY3_BANK_RESULT_EN
        check({tag, "_br_valid"}, 32'(bank_result_valid), 0);
        check({tag, "_br"}, 32'(bank_result), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // {bank a, bank b, gaps, sum, short_bank_err, digit_err}
        tbl[0] = '{"98761", "9876", 1'b0, 196, 1'b0, 1'b0};
        tbl[1] = '{"811111111111119", "234234234234278", 1'b0, 167, 1'b0, 1'b0};
        tbl[2] = '{"811111111111119", "234234234234278", 1'b1, 167, 1'b0, 1'b0};
        tbl[3] = '{"5", "12", 1'b0, 12, 1'b1, 1'b0};
        tbl[4] = '{"1<3", "9:", 1'b1, 103, 1'b0, 1'b1};
        tbl[5] = '{"91", "00", 1'b1, 91, 1'b0, 1'b0};

        rst         = 1'b1;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit       = '0;
        digit_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", 32'(digit_ready), 0);

        for (int i = 0; i < 6; i++) begin
            run(i);
        end

        // Reset in the middle of a bank, then replay the same stream.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_bank(tbl[1].a, 5, 1'b0);
        check("mid_scan_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        run(1);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
